// File: rtl/fpu_divsqrt_arbiter.sv
// Round-robin arbiter sharing one iterative FP div/sqrt unit among NUM_REQS requesters.
// One operation in flight; results routed back to the owner, fflags accumulated per requester.
module fpu_divsqrt_arbiter #(
  parameter int unsigned NUM_REQS   = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQS-1:0]            req_valid,
  output logic [NUM_REQS-1:0]            req_ready,
  input  logic [NUM_REQS-1:0]            req_op,
  input  logic [NUM_REQS*DATA_WIDTH-1:0] req_dataa,
  input  logic [NUM_REQS*DATA_WIDTH-1:0] req_datab,
  input  logic [NUM_REQS*TAG_WIDTH-1:0]  req_tag,
  output logic [NUM_REQS-1:0]            rsp_valid,
  input  logic [NUM_REQS-1:0]            rsp_ready,
  output logic [DATA_WIDTH-1:0]          rsp_result,
  output logic [TAG_WIDTH-1:0]           rsp_tag,
  output logic [4:0]                     rsp_fflags,
  output logic                           unit_req_valid,
  input  logic                           unit_req_ready,
  output logic                           unit_op,
  output logic [DATA_WIDTH-1:0]          unit_dataa,
  output logic [DATA_WIDTH-1:0]          unit_datab,
  input  logic                           unit_rsp_valid,
  output logic                           unit_rsp_ready,
  input  logic [DATA_WIDTH-1:0]          unit_result,
  input  logic [4:0]                     unit_fflags,
  input  logic [NUM_REQS-1:0]            fflags_clr,
  output logic [NUM_REQS*5-1:0]          fflags_sticky
);

  localparam int unsigned IdxW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e                  state_q;
  logic [IdxW-1:0]         rr_ptr_q, owner_q, grant_idx, cand_idx;
  logic                    grant_found, resp_fire;
  logic                    op_q;
  logic [DATA_WIDTH-1:0]   dataa_q, datab_q, result_q;
  logic [DATA_WIDTH-1:0]   sel_dataa, sel_datab;
  logic [TAG_WIDTH-1:0]    tag_q, sel_tag;
  logic [4:0]              fflags_q;
  logic [NUM_REQS*5-1:0]   sticky_q, sticky_d;
  int unsigned             cand;

  // Scan from rr_ptr upward with wrap; first valid requester wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int unsigned k = 0; k < NUM_REQS; k++) begin
      cand     = (32'(rr_ptr_q) + k) % NUM_REQS;
      cand_idx = IdxW'(cand);
      if (!grant_found && req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
    sel_dataa = req_dataa[32'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    sel_datab = req_datab[32'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    sel_tag   = req_tag[32'(grant_idx)*TAG_WIDTH +: TAG_WIDTH];
  end

  // req_ready is the only combinational output; gate it so reset forces it low at once.
  assign req_ready      = (state_q == StIdle && grant_found && !reset) ?
                          (NUM_REQS'(1) << grant_idx) : '0;
  assign unit_req_valid = (state_q == StIssue);
  assign unit_rsp_ready = (state_q == StWait);
  assign rsp_valid      = (state_q == StResp) ? (NUM_REQS'(1) << owner_q) : '0;
  assign resp_fire      = (state_q == StResp) && rsp_ready[owner_q];

  assign unit_op       = op_q;
  assign unit_dataa    = dataa_q;
  assign unit_datab    = datab_q;
  assign rsp_result    = result_q;
  assign rsp_tag       = tag_q;
  assign rsp_fflags    = fflags_q;
  assign fflags_sticky = sticky_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      op_q     <= 1'b0;
      dataa_q  <= '0;
      datab_q  <= '0;
      tag_q    <= '0;
      result_q <= '0;
      fflags_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (grant_found) begin
            owner_q <= grant_idx;
            op_q    <= req_op[grant_idx];
            dataa_q <= sel_dataa;
            datab_q <= sel_datab;
            tag_q   <= sel_tag;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          if (unit_req_ready) state_q <= StWait;
        end
        StWait: begin
          if (unit_rsp_valid) begin
            result_q <= unit_result;
            fflags_q <= unit_fflags;
            state_q  <= StResp;
          end
        end
        StResp: begin
          if (rsp_ready[owner_q]) begin
            rr_ptr_q <= IdxW'((32'(owner_q) + 1) % NUM_REQS);
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Clear takes effect before the OR, so a same-cycle clear keeps only the new flags.
  always_comb begin
    sticky_d = '0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      sticky_d[i*5 +: 5] = (fflags_clr[i] ? 5'b0 : sticky_q[i*5 +: 5]) |
                           ((resp_fire && owner_q == IdxW'(i)) ? fflags_q : 5'b0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sticky_q <= '0;
    else       sticky_q <= sticky_d;
  end

endmodule

// File: tb/tb_fpu_divsqrt_arbiter.sv
// Bench for fpu_divsqrt_arbiter: transaction-level model checked every cycle,
// directed scenarios with literal expectations, and a reactive stand-in for the unit.
module tb_fpu_divsqrt_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int TW = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid = '0, req_op = '0, rsp_ready = '1, fflags_clr = '0;
  logic [N-1:0]    req_ready, rsp_valid;
  logic [N*DW-1:0] req_dataa = '0, req_datab = '0;
  logic [N*TW-1:0] req_tag = '0;
  logic [DW-1:0]   rsp_result, unit_dataa, unit_datab;
  logic [TW-1:0]   rsp_tag;
  logic [4:0]      rsp_fflags;
  logic            unit_req_valid, unit_op, unit_rsp_ready;
  logic            unit_req_ready = 1'b0, unit_rsp_valid = 1'b0;
  logic [DW-1:0]   unit_result = '0;
  logic [4:0]      unit_fflags = '0;
  logic [N*5-1:0]  fflags_sticky;

  fpu_divsqrt_arbiter #(.NUM_REQS(N), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_dataa(req_dataa), .req_datab(req_datab), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_tag(rsp_tag), .rsp_fflags(rsp_fflags),
    .unit_req_valid(unit_req_valid), .unit_req_ready(unit_req_ready), .unit_op(unit_op),
    .unit_dataa(unit_dataa), .unit_datab(unit_datab),
    .unit_rsp_valid(unit_rsp_valid), .unit_rsp_ready(unit_rsp_ready),
    .unit_result(unit_result), .unit_fflags(unit_fflags),
    .fflags_clr(fflags_clr), .fflags_sticky(fflags_sticky)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Unit stand-in knobs
  int          unit_lat = 1;
  logic [31:0] next_result = '0;
  logic [4:0]  next_fflags = '0;

  // Model state: one transaction in progress, advanced by handshakes
  bit          m_busy;
  int          m_stage;  // 0 awaiting issue, 1 awaiting result, 2 awaiting response accept
  int          m_owner, m_ptr;
  logic        m_op;
  logic [31:0] m_a, m_b, m_res;
  logic [7:0]  m_tag;
  logic [4:0]  m_ff;
  logic [4:0]  m_sticky[N];
  int          glog[$];

  function automatic logic [N-1:0] rr_pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (ptr + k) % N;
      if (v[i]) return N'(1) << i;
    end
    return '0;
  endfunction

  initial begin
    logic [N-1:0] exp_rr;
    bit fire;
    forever begin
      @(negedge clk);
      if (reset) begin
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_unit_req_valid", unit_req_valid, 0);
        check("rst_unit_rsp_ready", unit_rsp_ready, 0);
        check("rst_sticky", fflags_sticky, 0);
        check("rst_unit_data", {unit_dataa, unit_datab}, 0);
        check("rst_rsp_data", {rsp_result, rsp_tag, rsp_fflags}, 0);
        m_busy = 0; m_stage = 0; m_ptr = 0; m_owner = 0;
        for (int i = 0; i < N; i++) m_sticky[i] = '0;
      end else begin
        exp_rr = m_busy ? '0 : rr_pick(req_valid, m_ptr);
        check("req_ready", req_ready, exp_rr);
        check("unit_req_valid", unit_req_valid, m_busy && m_stage == 0);
        check("unit_rsp_ready", unit_rsp_ready, m_busy && m_stage == 1);
        check("rsp_valid", rsp_valid, (m_busy && m_stage == 2) ? (N'(1) << m_owner) : '0);
        if (m_busy) begin
          check("unit_op", unit_op, m_op);
          check("unit_dataa", unit_dataa, m_a);
          check("unit_datab", unit_datab, m_b);
        end
        if (m_busy && m_stage == 2) begin
          check("rsp_result", rsp_result, m_res);
          check("rsp_tag", rsp_tag, m_tag);
          check("rsp_fflags", rsp_fflags, m_ff);
        end
        for (int i = 0; i < N; i++) check("sticky", fflags_sticky[i*5 +: 5], m_sticky[i]);
        for (int i = 0; i < N; i++) if (req_ready[i] && req_valid[i]) glog.push_back(i);
        fire = 0;
        if (!m_busy) begin
          for (int i = 0; i < N; i++) if (exp_rr[i]) begin
            m_busy = 1; m_stage = 0; m_owner = i; m_op = req_op[i];
            m_a = req_dataa[i*DW +: DW]; m_b = req_datab[i*DW +: DW]; m_tag = req_tag[i*TW +: TW];
          end
        end else begin
          case (m_stage)
            0: if (unit_req_ready) m_stage = 1;
            1: if (unit_rsp_valid) begin m_stage = 2; m_res = unit_result; m_ff = unit_fflags; end
            default: if (rsp_ready[m_owner]) begin
              m_busy = 0; m_ptr = (m_owner + 1) % N; fire = 1;
            end
          endcase
        end
        for (int i = 0; i < N; i++) if (fflags_clr[i]) m_sticky[i] = '0;
        if (fire) m_sticky[m_owner] = m_sticky[m_owner] | m_ff;
      end
    end
  end

  // Shared unit: answers unit_lat cycles after an issue handshake, shares the reset
  initial begin
    bit fire_issue, fire_cap;
    int lat_left;
    lat_left = 0;
    forever begin
      @(negedge clk);
      fire_issue = unit_req_valid && unit_req_ready;
      fire_cap   = unit_rsp_valid && unit_rsp_ready;
      @(posedge clk); #1;
      if (reset) begin
        lat_left = 0; unit_rsp_valid = 1'b0;
      end else begin
        if (fire_cap) unit_rsp_valid = 1'b0;
        if (fire_issue) lat_left = unit_lat;
        if (lat_left > 0) begin
          lat_left--;
          if (lat_left == 0) begin
            unit_rsp_valid = 1'b1; unit_result = next_result; unit_fflags = next_fflags;
          end
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_req(input int i, input bit op, input logic [31:0] a, input logic [31:0] b,
                         input logic [7:0] t);
    req_op[i] = op; req_dataa[i*DW +: DW] = a; req_datab[i*DW +: DW] = b;
    req_tag[i*TW +: TW] = t; req_valid[i] = 1'b1;
  endtask

  task automatic wait_grant(input int i);
    int n;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (req_ready[i] && req_valid[i]) break;
      if (++n >= 50) begin
        n_total++; $display("FAIL grant_timeout req %0d: got no grant, expected one", i); break;
      end
    end
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  // Returns at the negedge where rsp_valid[i] is seen
  task automatic wait_rv(input int i);
    int n;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (rsp_valid[i]) break;
      if (++n >= 50) begin
        n_total++; $display("FAIL rsp_timeout req %0d: got no response, expected one", i); break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, expected to finish");
    $fatal(1);
  end

  initial begin
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int n;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    cyc(1);
    unit_req_ready = 1'b1;

    // All requesters continuously valid: rotating grants
    glog.delete();
    next_result = 32'h12345678;
    for (int i = 0; i < N; i++) set_req(i, i[0], 32'h41000000 + i, 32'h40000000, 8'h10 + 8'(i));
    n = 0;
    while (glog.size() < 5 && n < 200) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid = '0;
    for (int k = 0; k < 5; k++) check("rr_order", (glog.size() > k) ? glog[k] : -1, exp_order[k]);
    cyc(10);

    // Sticky accumulation on req 1, then clear colliding with an NV response
    next_fflags = 5'b01000; set_req(1, 0, 32'h3F800000, 32'h00000000, 8'h21);
    wait_grant(1); wait_rv(1); cyc(1);
    next_fflags = 5'b00001; set_req(1, 1, 32'h40000000, 32'h00000000, 8'h22);
    wait_grant(1); wait_rv(1); cyc(1);
    @(negedge clk); check("sticky1_dz_nx", fflags_sticky[9:5], 5'b01001);
    cyc(1);
    next_fflags = 5'b10000; rsp_ready[1] = 1'b0; set_req(1, 1, 32'hBF800000, 32'h0, 8'h23);
    wait_grant(1); wait_rv(1); cyc(1);
    fflags_clr[1] = 1'b1; rsp_ready[1] = 1'b1;
    cyc(1);
    fflags_clr = '0;
    @(negedge clk); check("sticky1_clr_nv", fflags_sticky[9:5], 5'b10000);
    cyc(1);

    // Spurious unit result during ISSUE is ignored
    next_fflags = 5'b00000; unit_req_ready = 1'b0;
    set_req(3, 1, 32'h40800000, 32'h0, 8'hC3);
    wait_grant(3);
    unit_rsp_valid = 1'b1; unit_result = 32'hDEADBEEF; unit_fflags = 5'b11111;
    cyc(1);
    unit_rsp_valid = 1'b0;
    cyc(1);
    @(negedge clk);
    check("issue_hold_valid", unit_req_valid, 1);
    check("issue_no_rsp_ready", unit_rsp_ready, 0);
    check("issue_no_rsp", rsp_valid, 0);
    @(posedge clk); #1;
    next_result = 32'h40000000; unit_req_ready = 1'b1;
    wait_rv(3);
    check("sqrt_result", rsp_result, 32'h40000000);
    check("sqrt_tag", rsp_tag, 8'hC3);
    cyc(1);

    // Backpressure on both the unit issue and the response
    unit_req_ready = 1'b0; rsp_ready[0] = 1'b0; next_result = 32'h40200000;
    set_req(0, 0, 32'h40A00000, 32'h40000000, 8'h3C);
    wait_grant(0);
    set_req(3, 0, 32'h41200000, 32'h40000000, 8'h3D);
    repeat (5) begin
      @(negedge clk);
      check("bp_dataa", unit_dataa, 32'h40A00000);
      check("bp_no_grant", req_ready, 0);
      @(posedge clk); #1;
    end
    unit_req_ready = 1'b1;
    wait_rv(0);
    repeat (3) begin
      check("bp_rsp_valid", rsp_valid, 4'b0001);
      check("bp_rsp_result", rsp_result, 32'h40200000);
      check("bp_rsp_no_grant", req_ready, 0);
      @(posedge clk); #1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_ready[0] = 1'b1;
    wait_grant(3); wait_rv(3); cyc(1);

    // Single divide on req 2
    next_result = 32'h40400000; next_fflags = 5'b00000;
    set_req(2, 0, 32'h40400000, 32'h3F800000, 8'h5A);
    wait_grant(2); wait_rv(2);
    check("div_rsp_valid", rsp_valid, 4'b0100);
    check("div_rsp_tag", rsp_tag, 8'h5A);
    check("div_rsp_result", rsp_result, 32'h40400000);
    check("div_rsp_fflags", rsp_fflags, 5'b00000);
    cyc(1);
    @(negedge clk); check("div_sticky2", fflags_sticky[14:10], 5'b00000);
    cyc(1);

    // Reset while WAIT; rr_ptr is 3 beforehand, must restart at 0
    unit_lat = 20;
    set_req(1, 0, 32'h40E00000, 32'h40000000, 8'h77);
    wait_grant(1); cyc(1);
    @(negedge clk); check("in_wait", unit_rsp_ready, 1);
    @(posedge clk); #3;
    reset = 1'b1;
    set_req(0, 0, 32'h3F800000, 32'h3F800000, 8'h01);
    set_req(3, 0, 32'h3F800000, 32'h3F800000, 8'h04);
    #1;
    check("rst_async_rsp_ready", unit_rsp_ready, 0);
    check("rst_async_req_ready", req_ready, 0);
    check("rst_async_unit_data", unit_dataa, 0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0; unit_lat = 1;
    @(negedge clk); check("post_rst_grant", req_ready, 4'b0001);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_rv(0); cyc(1);
    wait_grant(3); wait_rv(3); cyc(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
